// File: rtl/ram_pkg.sv
// Shared defaults and the round-robin grant function used by both arbiters
// of the two-port RAM front end.
package ram_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 16;

    // Upper bound on requesters the grant function handles.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = 5;

    // One-hot grant to the first set bit of req at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_grant(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0]   g;
        logic                 found;
        int unsigned          idx;
        logic [MAX_IDX_W-1:0] sel;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                sel = idx[MAX_IDX_W-1:0];
                if (!found && req[sel]) begin
                    g[sel] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own priority pointer; combinational grant,
// pointer advances past the winner.
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] grant_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        grant_ext              = rr_grant(req_ext, 32'(ptr_q), NUM_REQ);
        // Grants are suppressed while reset is held low.
        grant                  = reset ? grant_ext[NUM_REQ-1:0] : '0;
        grant_idx              = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
        ptr_d = ptr_q;
        if (|grant) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
            else                                  ptr_d = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_tp_arbiter.sv
// Shares one write port and one registered-read port of a RAM between
// NUM_REQ requesters, routing each read response back to its issuer.
module ram_tp_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            wr_valid,
    output logic [NUM_REQ-1:0]            wr_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_REQ-1:0]            rd_valid,
    output logic [NUM_REQ-1:0]            rd_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          ram_cen,
    output logic                          ram_wen,
    output logic [ADDR_WIDTH-1:0]         ram_waddr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    output logic                          ram_ren,
    output logic [ADDR_WIDTH-1:0]         ram_raddr,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    logic [NUM_REQ-1:0] wr_grant;
    logic [NUM_REQ-1:0] rd_grant;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [NUM_REQ-1:0] rsp_sel_q;
    logic [NUM_REQ-1:0] rsp_sel_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (wr_valid),
        .grant     (wr_grant),
        .grant_idx (wr_idx)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (rd_valid),
        .grant     (rd_grant),
        .grant_idx (rd_idx)
    );

    always_comb begin
        wr_ready  = wr_grant;
        rd_ready  = rd_grant;
        ram_wen   = reset & (|wr_valid);
        ram_ren   = reset & (|rd_valid);
        ram_cen   = ram_wen | ram_ren;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        // Buses stay at zero unless a slice actually holds the grant.
        if (|wr_grant) begin
            ram_waddr = wr_addr[32'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata = wr_data[32'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (|rd_grant) begin
            ram_raddr = rd_addr[32'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
        rsp_sel_d = rd_grant;
        // A response in flight when reset asserts is dropped.
        rsp_valid = reset ? rsp_sel_q : '0;
        rsp_data  = ram_rdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) rsp_sel_q <= '0;
        else        rsp_sel_q <= rsp_sel_d;
    end

endmodule

// File: tb/tb_ram_tp_arbiter.sv
// Directed bench for ram_tp_arbiter with a behavioural registered-read RAM.
module tb_ram_tp_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NR-1:0]   wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
    logic [NR*AW-1:0] wr_addr, rd_addr;
    logic [NR*DW-1:0] wr_data;
    logic [DW-1:0]   rsp_data, ram_wdata, ram_rdata;
    logic            ram_cen, ram_wen, ram_ren;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [DW-1:0]   mem [16];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    ram_tp_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(16)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    // Registered read returns pre-write contents on a same-address collision.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clock) begin
        if (ram_cen && ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_cen && ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    initial begin
        reset    = 1'b0;
        wr_valid = '1;
        rd_valid = '1;
        for (int i = 0; i < NR; i++) begin
            wr_addr[i*AW +: AW] = AW'(8 + i);
            wr_data[i*DW +: DW] = 32'hA0 + 32'(i);
            rd_addr[i*AW +: AW] = AW'(i);
        end

        // Reset held with all requests asserted
        tick(); tick(); settle();
        chk("rst_wr_ready",  64'(wr_ready),  64'h0);
        chk("rst_rd_ready",  64'(rd_ready),  64'h0);
        chk("rst_cen",       64'(ram_cen),   64'h0);
        chk("rst_wen",       64'(ram_wen),   64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_waddr",     64'(ram_waddr), 64'h0);
        chk("rst_wdata",     64'(ram_wdata), 64'h0);
        chk("rst_raddr",     64'(ram_raddr), 64'h0);

        // Release: requester 0 first on both ports, then write rotation
        tick(); reset = 1'b1; settle();
        chk("rel_wr_ready", 64'(wr_ready),  64'b0001);
        chk("rel_rd_ready", 64'(rd_ready),  64'b0001);
        chk("rel_cen",      64'(ram_cen),   64'h1);
        chk("rr0_waddr",    64'(ram_waddr), 64'h8);
        chk("rr0_wdata",    64'(ram_wdata), 64'hA0);
        chk("rel_rsp0",     64'(rsp_valid), 64'h0);
        tick(); rd_valid = '0; settle();
        chk("rr1_ready", 64'(wr_ready),  64'b0010);
        chk("rr1_waddr", 64'(ram_waddr), 64'h9);
        chk("rr1_wdata", 64'(ram_wdata), 64'hA1);
        chk("rr1_rsp",   64'(rsp_valid), 64'b0001);
        chk("rr1_rdata", 64'(rsp_data),  64'h0);
        chk("rr1_ren",   64'(ram_ren),   64'h0);
        tick(); settle();
        chk("rr2_ready", 64'(wr_ready),  64'b0100);
        chk("rr2_waddr", 64'(ram_waddr), 64'hA);
        chk("rr2_wdata", 64'(ram_wdata), 64'hA2);
        chk("rr2_rsp",   64'(rsp_valid), 64'h0);
        tick(); settle();
        chk("rr3_ready", 64'(wr_ready),  64'b1000);
        chk("rr3_waddr", 64'(ram_waddr), 64'hB);
        chk("rr3_wdata", 64'(ram_wdata), 64'hA3);
        tick(); settle();
        chk("rr4_ready", 64'(wr_ready),  64'b0001);
        chk("rr4_waddr", 64'(ram_waddr), 64'h8);

        // Read routing: req2 writes addr 5, req1 reads it back
        tick();
        wr_valid = 4'b0100;
        wr_addr[2*AW +: AW] = 4'd5;
        wr_data[2*DW +: DW] = 32'hDEADBEEF;
        settle();
        chk("route_wr_ready", 64'(wr_ready),  64'b0100);
        chk("route_waddr",    64'(ram_waddr), 64'h5);
        tick();
        wr_valid = '0;
        rd_valid = 4'b0010;
        rd_addr[1*AW +: AW] = 4'd5;
        settle();
        chk("route_rd_ready", 64'(rd_ready),  64'b0010);
        chk("route_raddr",    64'(ram_raddr), 64'h5);
        chk("idle_wen",       64'(ram_wen),   64'h0);
        chk("idle_waddr",     64'(ram_waddr), 64'h0);
        chk("idle_wdata",     64'(ram_wdata), 64'h0);

        // Collision setup: addr 3 <= 0x11
        tick();
        rd_valid = '0;
        wr_valid = 4'b0001;
        wr_addr[0 +: AW] = 4'd3;
        wr_data[0 +: DW] = 32'h11;
        settle();
        chk("route_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("route_rsp_data",  64'(rsp_data),  64'hDEADBEEF);
        chk("col_wr0_ready",   64'(wr_ready),  64'b0001);
        tick();
        wr_data[0 +: DW] = 32'h22;
        rd_valid = 4'b0001;
        rd_addr[0 +: AW] = 4'd3;
        settle();
        chk("col_wr_ready", 64'(wr_ready), 64'b0001);
        chk("col_rd_ready", 64'(rd_ready), 64'b0001);
        tick(); wr_valid = '0; settle();
        chk("col_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("col_old_data",  64'(rsp_data),  64'h11);
        chk("col_rd2_ready", 64'(rd_ready),  64'b0001);
        tick(); rd_valid = '0; settle();
        chk("col_new_data", 64'(rsp_data), 64'h22);

        // Starvation: requesters 0 and 3 read continuously, rd ptr at 1
        tick();
        rd_valid = 4'b1001;
        rd_addr[0 +: AW]    = 4'd8;
        rd_addr[3*AW +: AW] = 4'd11;
        settle();
        chk("stv0_ready", 64'(rd_ready), 64'b1000);
        tick(); settle();
        chk("stv1_ready", 64'(rd_ready),  64'b0001);
        chk("stv1_rsp",   64'(rsp_valid), 64'b1000);
        chk("stv1_data",  64'(rsp_data),  64'hA3);
        tick(); settle();
        chk("stv2_ready", 64'(rd_ready),  64'b1000);
        chk("stv2_rsp",   64'(rsp_valid), 64'b0001);
        chk("stv2_data",  64'(rsp_data),  64'hA0);
        tick(); settle();
        chk("stv3_ready", 64'(rd_ready), 64'b0001);
        tick();
        rd_valid = 4'b1011;
        rd_addr[1*AW +: AW] = 4'd9;
        settle();
        chk("join_ready", 64'(rd_ready), 64'b0010);
        tick(); settle();
        chk("join_next_ready", 64'(rd_ready),  64'b1000);
        chk("join_rsp",        64'(rsp_valid), 64'b0010);
        chk("join_data",       64'(rsp_data),  64'hA1);

        // Reset right after a read is accepted
        tick();
        rd_valid = 4'b0100;
        rd_addr[2*AW +: AW] = 4'd10;
        settle();
        chk("mid_rd_ready", 64'(rd_ready), 64'b0100);
        tick(); reset = 1'b0; rd_valid = '0; settle();
        chk("mid_rsp_drop", 64'(rsp_valid), 64'h0);
        chk("mid_cen",      64'(ram_cen),   64'h0);
        tick(); settle();
        chk("mid_rsp_drop2", 64'(rsp_valid), 64'h0);
        tick();
        reset    = 1'b1;
        wr_valid = '1;
        rd_valid = '1;
        settle();
        chk("restart_wr_ready", 64'(wr_ready),  64'b0001);
        chk("restart_rd_ready", 64'(rd_ready),  64'b0001);
        chk("restart_rsp",      64'(rsp_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_tp_arbiter.md
# ram_tp_arbiter

Round-robin arbiter that shares one two-port RAM (one write port, one registered-read port) between `NUM_REQ` requesters. The write port and the read port are arbitrated independently, so the RAM can take one write and one read in the same cycle. The block drives the RAM port signals directly and routes each 1-cycle-latency read response back to the requester that issued it. It sits between the requester clients and the RAM instance.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: RAM data width.
- `DEPTH`, 16: RAM depth. Local `ADDR_WIDTH = $clog2(DEPTH)`.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_valid`  in  NUM_REQ  per-requester write request.
- `wr_ready`  out  NUM_REQ  write grant, one-hot or zero.
- `wr_addr`  in  NUM_REQ*ADDR_WIDTH  packed write addresses, requester i at slice i.
- `wr_data`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `rd_valid`  in  NUM_REQ  per-requester read request.
- `rd_ready`  out  NUM_REQ  read grant, one-hot or zero.
- `rd_addr`  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
- `rsp_valid`  out  NUM_REQ  read-response strobe, one-hot or zero.
- `rsp_data`  out  DATA_WIDTH  read data shared by all requesters; qualified by `rsp_valid`.
- `ram_cen`  out  1  RAM chip enable.
- `ram_wen`  out  1  RAM write enable.
- `ram_waddr`  out  ADDR_WIDTH  RAM write address.
- `ram_wdata`  out  DATA_WIDTH  RAM write data.
- `ram_ren`  out  1  RAM read enable.
- `ram_raddr`  out  ADDR_WIDTH  RAM read address.
- `ram_rdata`  in  DATA_WIDTH  RAM registered read data.

## Operation
- **Transfer:** a transfer occurs when `x_valid[i] && x_ready[i]` at a rising edge. Requesters hold `valid`, `addr` and `data` stable until ready.
- **Grant:** each port has its own priority pointer `ptr` (0..NUM_REQ-1).
  - Grant goes to the first asserted `valid` found scanning from `ptr` upward, wrapping modulo NUM_REQ.
  - The grant is combinational from `valid` and `ptr`. `ready` may depend on `valid`; `valid` must not depend on `ready`.
- **Pointer update:** after a grant to requester i, `ptr <= (i+1) mod NUM_REQ`. With no grant, `ptr` holds.
- **Fairness:** a continuously asserted request is granted within NUM_REQ cycles.
- **Write path:**
  - `ram_wen = |wr_valid`.
  - `ram_waddr` and `ram_wdata` are muxed from the granted slice; they are 0 when idle.
- **Read path:**
  - `ram_ren = |rd_valid`; `ram_raddr` is muxed from the granted slice.
  - A registered one-hot `rsp_sel` captures the read grant.
  - `rsp_valid = rsp_sel`, valid in the cycle after acceptance.
  - `rsp_data = ram_rdata`, passed through combinationally.
- **Chip enable:** `ram_cen = ram_wen | ram_ren`.
- **Same-address collision:** a write and a read to the same address in the same cycle return the OLD data. The new data is visible to reads accepted from the next cycle on.
- **Reset:** while `reset` is low, all `ready` outputs and `ram_cen`/`ram_wen`/`ram_ren` are forced to 0.
  - Both `ptr` registers load 0 and `rsp_sel` loads 0.
  - A response pending when reset asserts is dropped; no `rsp_valid` is issued for it.

## Timing
- Reset values:
  - `wr_ready`, `rd_ready`, `rsp_valid`: 0.
  - `ram_cen`, `ram_wen`, `ram_ren`: 0.
  - `ram_waddr`, `ram_wdata`, `ram_raddr`: 0.
  - `rsp_data` follows `ram_rdata`.
- Write latency: 0 cycles to grant; data is in RAM at the accepting edge.
- Read latency: request accepted at edge N; `rsp_valid`/`rsp_data` are valid during cycle N+1.
- Throughput: one write plus one read per cycle, sustained. Back-to-back reads from the same requester are allowed.
- Only the `ptr` and `rsp_sel` registers are sequential; all other outputs are combinational.

## Structure
- Shared package `ram_pkg`: default widths, and a function computing the round-robin one-hot grant from a request vector and a pointer.
- One sub-module, `rr_arbiter` (parameter `NUM_REQ`; inputs `clock`, `reset`, `req`; outputs `grant` (one-hot) and `grant_idx`). It owns its pointer and is instantiated twice, once for the write port and once for the read port.
- The RAM itself is not instantiated inside this block.

## Test plan
- **Reset:** hold `reset` low with all valids high → all readies, `ram_cen`, and `rsp_valid` stay 0. Release reset → requester 0 is granted on both ports in the first cycle.
- **Round-robin write:** NUM_REQ=4, all `wr_valid` held high → grants go 0,1,2,3,0 in consecutive cycles; `ram_waddr`/`ram_wdata` match the granted slice each cycle.
- **Read routing:** requester 2 writes 0xDEADBEEF to addr 5; requester 1 then reads addr 5 → next cycle `rsp_valid = 4'b0010` and `rsp_data = 0xDEADBEEF`.
- **Collision:** addr 3 holds 0x11. Same-cycle write of 0x22 and read of addr 3 → response is 0x11. A read of addr 3 in the following cycle → 0x22.
- **Starvation bound:** requesters 0 and 3 read continuously; requester 3 is granted at least every 2 cycles. Requester 1 then joins → it is granted within 4 cycles.
- **Reset mid-operation:** assert reset in the cycle after a read is accepted → no `rsp_valid` is seen, and both pointers restart at 0.
